// File: rtl/imem_access_arbiter.sv
// ---------------------------------------------------------------------------
// imem_access_arbiter
//   Owns the single read/write port of the instruction memory. The port is
//   shared between the fetch stage and a program loader.
//   BOOT: the loader streams the program image in. Fetch is held off.
//   RUN : fetch normally wins the port. A loader write that has waited
//         MAX_WAIT cycles is force-granted, which stalls fetch for one cycle.
//   Fetch read latency is one cycle.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   fetch_req/addr  fetch request and byte address (PC)
//   fetch_data      instruction word (NOP for an out-of-range fetch)
//   fetch_valid     registered; response to the fetch accepted last cycle
//   fetch_stall     combinational; fetch not accepted, so PC must hold
//   ld_valid/addr/data  loader write request
//   ld_ready        combinational; loader write accepted this cycle
//   ld_done         one-cycle pulse that ends BOOT
//   boot_done       1 in RUN
//   boot_words      words accepted during BOOT (saturating)
//   mem_*           synchronous single-port array interface
// ---------------------------------------------------------------------------
module imem_access_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 8,
  parameter bit BOOT_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic [31:0]       fetch_data,
  output logic              fetch_valid,
  output logic              fetch_stall,
  input  logic              ld_valid,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  input  logic              ld_done,
  output logic              boot_done,
  output logic [15:0]       boot_words,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic {ST_BOOT, ST_RUN} state_t;
  localparam state_t RST_STATE = BOOT_EN ? ST_BOOT : ST_RUN;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic                fetch_oor_q, fetch_oor_d;
  logic [31:0]         fetch_data_q, fetch_data_d;
  logic [15:0]         boot_words_q, boot_words_d;

  logic [ADDR_W-1:0]   fetch_idx, ld_idx;
  logic                fetch_oor, ld_oor;
  logic                in_boot, grant_ld, fetch_acc;

  // Byte-offset bits carry no information for word-aligned accesses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr[1:0], ld_addr[1:0]};

  assign fetch_idx = fetch_addr[ADDR_W+1:2];
  assign ld_idx    = ld_addr[ADDR_W+1:2];
  assign fetch_oor = |fetch_addr[31:ADDR_W+2];
  assign ld_oor    = |ld_addr[31:ADDR_W+2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RST_STATE;
      wait_cnt_q    <= '0;
      fetch_valid_q <= 1'b0;
      fetch_oor_q   <= 1'b0;
      fetch_data_q  <= '0;
      boot_words_q  <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_oor_q   <= fetch_oor_d;
      fetch_data_q  <= fetch_data_d;
      boot_words_q  <= boot_words_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = '0;
    boot_words_d  = boot_words_q;
    in_boot       = (state_q == ST_BOOT);
    grant_ld      = 1'b0;
    ld_ready      = 1'b0;
    fetch_stall   = 1'b0;
    fetch_acc     = 1'b0;

    if (in_boot) begin
      // Loader owns the port outright; fetch is held regardless of request.
      ld_ready    = 1'b1;
      fetch_stall = 1'b1;
      grant_ld    = ld_valid;
      if (ld_valid) begin
        boot_words_d = sat_inc16(boot_words_q);
      end
      if (ld_done) begin
        state_d = ST_RUN;
      end
    end else begin
      grant_ld    = ld_valid & (~fetch_req | (wait_cnt_q == WAIT_MAX));
      ld_ready    = grant_ld;
      fetch_stall = fetch_req & grant_ld;
      fetch_acc   = fetch_req & ~grant_ld;
      // Counts cycles of a blocked write; any grant or idle loader clears it.
      if (ld_valid && !grant_ld && (wait_cnt_q != WAIT_MAX)) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end

    mem_addr  = grant_ld ? ld_idx : fetch_idx;
    mem_we    = grant_ld & ~ld_oor;
    mem_wdata = ld_data;

    // The array read data is only valid in the response cycle, so the word is
    // passed straight through then and captured to hold it afterwards.
    fetch_data    = fetch_valid_q ? (fetch_oor_q ? 32'h0000_0000 : mem_rdata)
                                  : fetch_data_q;
    fetch_data_d  = fetch_data;
    fetch_valid_d = fetch_acc;
    fetch_oor_d   = fetch_acc ? fetch_oor : fetch_oor_q;
  end

  assign fetch_valid = fetch_valid_q;
  assign boot_done   = (state_q == ST_RUN);
  assign boot_words  = boot_words_q;

endmodule

// File: tb/tb_imem_access_arbiter.sv
module tb_imem_access_arbiter;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic [31:0]       fetch_data;
  logic              fetch_valid;
  logic              fetch_stall;
  logic              ld_valid;
  logic [31:0]       ld_addr;
  logic [31:0]       ld_data;
  logic              ld_ready;
  logic              ld_done;
  logic              boot_done;
  logic [15:0]       boot_words;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  always #5 clk = ~clk;

  imem_access_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(8), .BOOT_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .fetch_valid(fetch_valid), .fetch_stall(fetch_stall),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done),
    .boot_done(boot_done), .boot_words(boot_words),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port array model.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else        mem_rdata     <= mem[mem_addr];
  end

  typedef struct {
    logic        freq;
    logic [31:0] faddr;
    logic        lv;
    logic [31:0] la;
    logic [31:0] ld;
    logic        ldone;
    logic        e_stall;
    logic        e_rdy;
    logic        e_we;
    logic        e_fv;
    logic [31:0] e_fd;
    logic        e_bd;
    logic [15:0] e_bw;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic addv(input logic freq, input logic [31:0] faddr,
                      input logic lv, input logic [31:0] la, input logic [31:0] ld,
                      input logic ldone, input logic e_stall, input logic e_rdy,
                      input logic e_we, input logic e_fv, input logic [31:0] e_fd,
                      input logic e_bd, input logic [15:0] e_bw);
    vec_t v;
    v.freq = freq; v.faddr = faddr; v.lv = lv; v.la = la; v.ld = ld; v.ldone = ldone;
    v.e_stall = e_stall; v.e_rdy = e_rdy; v.e_we = e_we; v.e_fv = e_fv;
    v.e_fd = e_fd; v.e_bd = e_bd; v.e_bw = e_bw;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; fetch_req = 0; fetch_addr = 0; ld_valid = 0; ld_addr = 0;
    ld_data = 0; ld_done = 0;

    // Each row: inputs for one cycle, then outputs seen mid-cycle.
    //   freq faddr  lv la      ld            done stl rdy we fv fd            bd bw
    // BOOT load; fetch requests are present but never accepted.
    addv(1, 32'h0,  1, 32'h0,  32'h01095020, 0,  1,  1,  1, 0, 32'h0,        0, 0);
    addv(1, 32'h0,  1, 32'h4,  32'hAC0A0000, 0,  1,  1,  1, 0, 32'h0,        0, 1);
    addv(1, 32'h0,  1, 32'h8,  32'h01495822, 0,  1,  1,  1, 0, 32'h0,        0, 2);
    addv(1, 32'h0,  1, 32'hC,  32'h1168FFFC, 0,  1,  1,  1, 0, 32'h0,        0, 3);
    addv(1, 32'h0,  1, 32'h10, 32'hAC0A0000, 1,  1,  1,  1, 0, 32'h0,        0, 4);
    // RUN: fetch latency and back-to-back fetches.
    addv(1, 32'h8,  0, 32'h0,  32'h0,        0,  0,  0,  0, 0, 32'h0,        1, 5);
    addv(1, 32'h0,  0, 32'h0,  32'h0,        0,  0,  0,  0, 1, 32'h01495822, 1, 5);
    addv(1, 32'h4,  0, 32'h0,  32'h0,        0,  0,  0,  0, 1, 32'h01095020, 1, 5);
    // ld_done in RUN is ignored.
    addv(0, 32'h0,  0, 32'h0,  32'h0,        1,  0,  0,  0, 1, 32'hAC0A0000, 1, 5);
    addv(0, 32'h0,  0, 32'h0,  32'h0,        0,  0,  0,  0, 0, 32'hAC0A0000, 1, 5);
    // Out-of-range fetch returns NOP; out-of-range write is accepted and dropped.
    addv(1, 32'h1000, 0, 32'h0, 32'h0,       0,  0,  0,  0, 0, 32'hAC0A0000, 1, 5);
    addv(0, 32'h0,  1, 32'h1000, 32'h12345678, 0, 0, 1,  0, 1, 32'h0,        1, 5);
    addv(0, 32'h0,  0, 32'h0,  32'h0,        0,  0,  0,  0, 0, 32'h0,        1, 5);
    // Starvation: 8 blocked cycles, then a forced grant.
    addv(1, 32'h0,  1, 32'h10, 32'hDEADBEEF, 0,  0,  0,  0, 0, 32'h0,        1, 5);
    for (int i = 0; i < 7; i++)
      addv(1, 32'h0, 1, 32'h10, 32'hDEADBEEF, 0, 0,  0,  0, 1, 32'h01095020, 1, 5);
    addv(1, 32'h0,  1, 32'h10, 32'hDEADBEEF, 0,  1,  1,  1, 1, 32'h01095020, 1, 5);
    addv(1, 32'h10, 0, 32'h0,  32'h0,        0,  0,  0,  0, 0, 32'h01095020, 1, 5);
    addv(0, 32'h0,  0, 32'h0,  32'h0,        0,  0,  0,  0, 1, 32'hDEADBEEF, 1, 5);
    // Write in cycle N is visible to a fetch in cycle N+1.
    addv(0, 32'h0,  1, 32'h8,  32'hCAFEF00D, 0,  0,  1,  1, 0, 32'hDEADBEEF, 1, 5);
    addv(1, 32'h8,  0, 32'h0,  32'h0,        0,  0,  0,  0, 0, 32'hDEADBEEF, 1, 5);
    addv(0, 32'h0,  0, 32'h0,  32'h0,        0,  0,  0,  0, 1, 32'hCAFEF00D, 1, 5);

    // Reset state.
    #3;
    chk("reset fetch_valid", -1, fetch_valid, 0);
    chk("reset fetch_data",  -1, fetch_data,  0);
    chk("reset boot_done",   -1, boot_done,   0);
    chk("reset boot_words",  -1, boot_words,  0);
    chk("reset fetch_stall", -1, fetch_stall, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      fetch_req = vecs[i].freq; fetch_addr = vecs[i].faddr;
      ld_valid = vecs[i].lv; ld_addr = vecs[i].la; ld_data = vecs[i].ld;
      ld_done = vecs[i].ldone;
      #3;
      chk("fetch_stall", i, fetch_stall, vecs[i].e_stall);
      chk("ld_ready",    i, ld_ready,    vecs[i].e_rdy);
      chk("mem_we",      i, mem_we,      vecs[i].e_we);
      chk("fetch_valid", i, fetch_valid, vecs[i].e_fv);
      chk("fetch_data",  i, fetch_data,  vecs[i].e_fd);
      chk("boot_done",   i, boot_done,   vecs[i].e_bd);
      chk("boot_words",  i, boot_words,  vecs[i].e_bw);
      @(posedge clk); #1;
    end

    // Asynchronous reset one cycle after a fetch is accepted.
    fetch_req = 1; fetch_addr = 32'h4; ld_valid = 0; ld_done = 0;
    @(posedge clk); #1;
    fetch_req = 0;
    chk("pre-reset fetch_valid", 100, fetch_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("async reset fetch_valid", 101, fetch_valid, 0);
    chk("async reset fetch_data",  101, fetch_data,  0);
    chk("async reset boot_done",   101, boot_done,   0);
    chk("async reset boot_words",  101, boot_words,  0);
    chk("async reset fetch_stall", 101, fetch_stall, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    ld_done = 1;
    @(posedge clk); #1;
    ld_done = 0;
    chk("re-run boot_done",  102, boot_done,  1);
    chk("re-run boot_words", 102, boot_words, 0);
    fetch_req = 1; fetch_addr = 32'h4;
    #3;
    chk("re-run fetch_stall", 103, fetch_stall, 0);
    @(posedge clk); #1;
    fetch_req = 0;
    #3;
    chk("re-run fetch_valid", 104, fetch_valid, 1);
    chk("re-run fetch_data",  104, fetch_data,  32'hAC0A0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
